vga_sync_gen: RTL

VGA raster timing generator sitting directly downstream of the pixel clock divider. It runs on the system clock and advances one pixel position per pixel-enable strobe from the divider. From horizontal and vertical counters it produces hsync/vsync, the active-video flag, pixel coordinates and line/frame start strobes for the pixel-colour logic. Default timing is 640x480@60 (800x525 total).

---
 rtl/vga_timing_pkg.sv | 53 +++++
 rtl/vga_axis_counter.sv | 41 ++++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing: default 640x480@60 constants, axis phase enum, colour-bar palette.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

  function automatic phase_t phase_of(input int cnt, input int active, input int fp,
                                      input int sync);
    if (cnt < active)                 return PH_ACTIVE;
    else if (cnt < active + fp)       return PH_FRONT;
    else if (cnt < active + fp + sync) return PH_SYNC;
    else                              return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter exposing the post-increment count,
// the wrap strobe and the phase of that next count, so the caller can register aligned outputs.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [CW-1:0] cnt_next,
  output logic          wrap,
  output logic [1:0]    phase
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

  logic [CW-1:0] cnt;

  always_comb begin
    wrap     = inc && (cnt == LAST);
    cnt_next = cnt;
    if (inc) begin
      if (cnt == LAST) cnt_next = '0;
      else             cnt_next = cnt + 1'b1;
    end
    phase = phase_of(int'(cnt_next), ACTIVE, FP, SYNC);
  end

  // Parked on the last position so the first increment after reset lands on 0 with a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= LAST;
    else     cnt <= cnt_next;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: registered sync, video_on, x/y and line/frame strobes, one pixel per pix_en.
// Optional colour-bar test pattern on rgb when VGA_SYNC_TEST_PATTERN_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = 0,
  localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW      = $clog2((H_TOT > V_TOT) ? H_TOT : V_TOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
`ifdef VGA_SYNC_TEST_PATTERN_EN
  output logic [11:0]   rgb,
`endif
  output logic          line_start,
  output logic          frame_start
);

  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [CW-1:0] h_next, v_next;
  logic          h_wrap, v_wrap;
  logic [1:0]    h_phase, v_phase;
  logic          video_on_next;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .inc     (pix_en),
    .cnt_next(h_next),
    .wrap    (h_wrap),
    .phase   (h_phase)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .inc     (pix_en && h_wrap),
    .cnt_next(v_next),
    .wrap    (v_wrap),
    .phase   (v_phase)
  );

  assign video_on_next = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

  // Everything is decoded from the next counts, so levels line up with x/y on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
      if (pix_en) begin
        x        <= h_next;
        y        <= v_next;
        video_on <= video_on_next;
        hsync    <= (h_phase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
        vsync    <= (v_phase == PH_SYNC) ? SYNC_ACT : ~SYNC_ACT;
      end
    end
  end

`ifdef VGA_SYNC_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'd7;
    if (int'(h_next) / BAR_W < 8) bar_idx = 3'(int'(h_next) / BAR_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rgb <= BAR_BLACK;
    else if (pix_en) rgb <= video_on_next ? bar_colour(bar_idx) : BAR_BLACK;
  end
`endif

endmodule
